sum_result_tx: RTL

Serial result transmitter for the 8-bit adder datapath. It captures one 9-bit adder result (8-bit sum plus carry-out) through a valid/ready handshake and shifts it out on a single pin as an asynchronous frame: start bit, data LSB first, stop bit. It sits on the output side of the adder, next to the tile output pins, and carries results off-chip over one `uo_out` bit.

---
 rtl/sum_tx_pkg.sv | 15 +
 rtl/bit_timer.sv | 31 +++
 rtl/sum_result_tx.sv | 101 ++++++++++
 3 files changed

// File: rtl/sum_tx_pkg.sv
// Shared types and widths for the adder result serial transmitter.
package sum_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned SUM_W            = 8;
  localparam int unsigned RESULT_W         = SUM_W + 1;
  localparam int unsigned CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: tick marks the last clock of each serial bit.
module bit_timer
  import sum_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Explicit wrap so non-power-of-two periods work.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/sum_result_tx.sv
// Serial transmitter for one {carry, sum} result: start bit, data LSB first, stop bit.
module sum_result_tx
  import sum_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_W       = RESULT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              tick;
  logic              accept_c;
  logic              tx_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  assign in_ready = (state == IDLE);
  assign accept_c = in_valid & in_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(accept_c),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && (bit_idx == LAST_IDX)) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs lag the state by one cycle; busy still high in the first IDLE
  // cycle is what marks the end of a completed frame.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state != IDLE);
    done_nxt = (state == IDLE) & busy;
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // Payload is captured only on the handshake and shifted once per data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (accept_c) begin
      shreg   <= in_data;
      bit_idx <= '0;
    end else if ((state == DATA) && tick) begin
      shreg   <= DATA_W'(shreg >> 1);
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

endmodule
